// File: rtl/debounce_strobe.sv
// Debounced level D with a one-cycle enable strobe for a downstream flop.
// Define DEBOUNCE_EDGE_EN to add the registered rise/fall edge pulses.
module debounce_strobe #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic D,
    output logic en,
    output logic dbg_state_o
`ifdef DEBOUNCE_EDGE_EN
    ,
    output logic rise,
    output logic fall
`endif
);

    localparam int CW = $clog2(DB_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   s;
    state_e                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   d_q;
    logic                   en_q;
`ifdef DEBOUNCE_EDGE_EN
    logic                   rise_q;
    logic                   fall_q;
`endif

    // din enters the design only through the head of the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            state_q <= STABLE;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            en_q    <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
`endif
        end else begin
            sync_q <= sync_d;
            en_q   <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`endif
            case (state_q)
                STABLE: begin
                    if (s != d_q) begin
                        state_q <= COUNTING;
                        cnt_q   <= CNT_ONE;
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                COUNTING: begin
                    if (s == d_q) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Mismatch held for DB_CYCLES samples: accept it.
                        d_q     <= s;
                        en_q    <= 1'b1;
`ifdef DEBOUNCE_EDGE_EN
                        rise_q  <= s;
                        fall_q  <= ~s;
`endif
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign D           = d_q;
    assign en          = en_q;
    assign dbg_state_o = state_q;
`ifdef DEBOUNCE_EDGE_EN
    assign rise        = rise_q;
    assign fall        = fall_q;
`endif

endmodule

// File: tb/tb_debounce_strobe.sv
// Directed bench for debounce_strobe: a default instance (2 stages, 4 samples)
// and a swept instance (3 stages, 2 samples). Edges are counted from 1.
module tb_debounce_strobe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din_a = 1'b0;
    logic din_b = 1'b0;
    logic d_a, en_a, st_a;
    logic d_b, en_b, st_b;
`ifdef DEBOUNCE_EDGE_EN
    logic rise_a, fall_a, rise_b, fall_b;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    debounce_strobe u_def (
        .clk(clk), .rst(rst), .din(din_a), .D(d_a), .en(en_a), .dbg_state_o(st_a)
`ifdef DEBOUNCE_EDGE_EN
        , .rise(rise_a), .fall(fall_a)
`endif
    );

    debounce_strobe #(.SYNC_STAGES(3), .DB_CYCLES(2)) u_swp (
        .clk(clk), .rst(rst), .din(din_b), .D(d_b), .en(en_b), .dbg_state_o(st_b)
`ifdef DEBOUNCE_EDGE_EN
        , .rise(rise_b), .fall(fall_b)
`endif
    );

    // Advance past the next rising edge; registered outputs are then settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_a = 1'b0; din_b = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_a = 1'b1; din_b = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_cmp++; if (d_a !== 1'b0) begin n_err++; $display("FAIL reset_hold_D edge %0d: got %b want 0", k, d_a); end
            n_cmp++; if (en_a !== 1'b0) begin n_err++; $display("FAIL reset_hold_en edge %0d: got %b want 0", k, en_a); end
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp++; if (en_a !== (k == 6)) begin n_err++; $display("FAIL reset_rel_en edge %0d: got %b want %b", k, en_a, k == 6); end
            n_cmp++; if (d_a !== (k >= 6)) begin n_err++; $display("FAIL reset_rel_D edge %0d: got %b want %b", k, d_a, k >= 6); end
            n_cmp++; if (en_b !== (k == 5)) begin n_err++; $display("FAIL reset_rel_swp_en edge %0d: got %b want %b", k, en_b, k == 5); end
            n_cmp++; if (d_b !== (k >= 5)) begin n_err++; $display("FAIL reset_rel_swp_D edge %0d: got %b want %b", k, d_b, k >= 5); end
        end
    endtask

    task automatic test_clean_step();
        do_reset();
        din_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            n_cmp++; if (en_a !== (k == 6)) begin n_err++; $display("FAIL step_en edge %0d: got %b want %b", k, en_a, k == 6); end
            n_cmp++; if (d_a !== (k >= 6)) begin n_err++; $display("FAIL step_D edge %0d: got %b want %b", k, d_a, k >= 6); end
            n_cmp++; if (st_a !== (k >= 3 && k <= 5)) begin n_err++; $display("FAIL step_state edge %0d: got %b want %b", k, st_a, (k >= 3 && k <= 5)); end
`ifdef DEBOUNCE_EDGE_EN
            n_cmp++; if (rise_a !== (k == 6)) begin n_err++; $display("FAIL step_rise edge %0d: got %b want %b", k, rise_a, k == 6); end
            n_cmp++; if (fall_a !== 1'b0) begin n_err++; $display("FAIL step_fall edge %0d: got %b want 0", k, fall_a); end
`endif
        end
    endtask

    task automatic test_bounce();
        int k;
        do_reset();
        k = 0;
        for (int r = 0; r < 4; r++) begin
            for (int p = 0; p < 6; p++) begin
                din_a = (p < 3);
                tick(); k++;
                n_cmp++; if (en_a !== 1'b0) begin n_err++; $display("FAIL bounce_en edge %0d: got %b want 0", k, en_a); end
                n_cmp++; if (d_a !== 1'b0) begin n_err++; $display("FAIL bounce_D edge %0d: got %b want 0", k, d_a); end
            end
        end
        for (int p = 0; p < 6; p++) begin
            tick(); k++;
            n_cmp++; if (en_a !== 1'b0 || d_a !== 1'b0) begin n_err++; $display("FAIL bounce_tail edge %0d: got en=%b D=%b want 0/0", k, en_a, d_a); end
        end
    endtask

    task automatic test_bounce_settle();
        logic [4:0] pat;
        int pulses;
        pat = 5'b10101;
        pulses = 0;
        do_reset();
        for (int k = 1; k <= 14; k++) begin
            din_a = (k <= 5) ? pat[5-k] : 1'b1;
            tick();
            if (en_a === 1'b1) pulses++;
            n_cmp++; if (en_a !== (k == 10)) begin n_err++; $display("FAIL settle_en edge %0d: got %b want %b", k, en_a, k == 10); end
            n_cmp++; if (d_a !== (k >= 10)) begin n_err++; $display("FAIL settle_D edge %0d: got %b want %b", k, d_a, k >= 10); end
        end
        n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL settle_pulses: got %0d want 1", pulses); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        din_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) rst = 1'b1;
            tick();
            n_cmp++; if (en_a !== 1'b0 || d_a !== 1'b0) begin n_err++; $display("FAIL midrst_pre edge %0d: got en=%b D=%b want 0/0", k, en_a, d_a); end
        end
        rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            n_cmp++; if (en_a !== (k == 6)) begin n_err++; $display("FAIL midrst_en edge %0d: got %b want %b", k, en_a, k == 6); end
            n_cmp++; if (d_a !== (k >= 6)) begin n_err++; $display("FAIL midrst_D edge %0d: got %b want %b", k, d_a, k >= 6); end
        end
    endtask

    task automatic test_reset_at_accept();
        do_reset();
        din_a = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            rst = (k == 6);
            tick();
            n_cmp++; if (en_a !== 1'b0 || d_a !== 1'b0) begin n_err++; $display("FAIL acceptrst edge %0d: got en=%b D=%b want 0/0", k, en_a, d_a); end
        end
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        do_reset();
        din_b = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++; if (en_b !== (k == 5)) begin n_err++; $display("FAIL swp_rise_en edge %0d: got %b want %b", k, en_b, k == 5); end
            n_cmp++; if (d_b !== (k >= 5)) begin n_err++; $display("FAIL swp_rise_D edge %0d: got %b want %b", k, d_b, k >= 5); end
        end
        din_b = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_cmp++; if (en_b !== (k == 5)) begin n_err++; $display("FAIL swp_fall_en edge %0d: got %b want %b", k, en_b, k == 5); end
            n_cmp++; if (d_b !== (k < 5)) begin n_err++; $display("FAIL swp_fall_D edge %0d: got %b want %b", k, d_b, k < 5); end
`ifdef DEBOUNCE_EDGE_EN
            n_cmp++; if (fall_b !== (k == 5)) begin n_err++; $display("FAIL swp_fall_pulse edge %0d: got %b want %b", k, fall_b, k == 5); end
            n_cmp++; if (rise_b !== 1'b0) begin n_err++; $display("FAIL swp_rise_pulse edge %0d: got %b want 0", k, rise_b); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_bounce_settle();
        test_reset_mid();
        test_reset_at_accept();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
